// File: rtl/ir_scan_intf.sv
// IR line-sensor front end: powers the emitters, scans an ADC128S-style SPI ADC,
// inverts and averages each channel, and publishes a thresholded result set.
module ir_scan_intf #(
  parameter int NUM_CH     = 8,
  parameter int SCLK_DIV   = 32,
  parameter int SETTLE_CYC = 1024,
  parameter int PERIOD_CYC = 8192,
  parameter int AVG_LOG2   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [11:0]           line_thresh,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCLK,
  output logic                  SS_n,
  output logic                  IR_en,
  output logic [12*NUM_CH-1:0]  ir_data,
  output logic                  ir_vld,
  output logic                  line_present
);

  localparam int FRAMES    = NUM_CH + 1;
  localparam int HALF      = SCLK_DIV / 2;
  localparam int GAP_CYC   = 2;
  localparam int LAST_EVT  = 32;
  localparam int ACC_W     = 12 + AVG_LOG2;
  localparam int NSCAN     = 1 << AVG_LOG2;
  localparam int SW        = AVG_LOG2 + 1;
  localparam int TW        = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
  localparam int CMAX      = (SETTLE_CYC > HALF) ? SETTLE_CYC : HALF;
  localparam int CW        = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_FRAME, S_GAP, S_ACCUM, S_PUBLISH
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [5:0]           evt_q, evt_d;
  logic [3:0]           frame_q, frame_d;
  logic [15:0]          tx_q, tx_d;
  logic [15:0]          rx_q, rx_d;
  logic                 sclk_q, sclk_d;
  logic                 ss_n_q, ss_n_d;
  logic                 mosi_q, mosi_d;
  logic                 ir_en_q, ir_en_d;
  logic [ACC_W-1:0]     acc_q [NUM_CH];
  logic [ACC_W-1:0]     acc_d [NUM_CH];
  logic [SW-1:0]        scan_cnt_q, scan_cnt_d;
  logic [NUM_CH-1:0][11:0] ir_data_q, ir_data_d;
  logic                 line_q, line_d;
  logic                 vld_q, vld_d;

  logic                 scan_start;
  logic [11:0]          inv_sample;

  // Frame j addresses channel j; the trailing extra frame only flushes the ADC pipeline.
  function automatic logic [15:0] addr_word(input logic [3:0] f);
    return (f < 4'(NUM_CH)) ? {2'b00, f[2:0], 11'b0} : 16'h0000;
  endfunction

  assign scan_start = en && (tmr_q == TW'(PERIOD_CYC - 1));
  assign tmr_d      = (!en || scan_start) ? '0 : tmr_q + 1'b1;
  assign inv_sample = ~rx_q[11:0];

  // NOTE: every signal assigned here gets its default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    evt_d      = evt_q;
    frame_d    = frame_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    ir_en_d    = ir_en_q;
    acc_d      = acc_q;
    scan_cnt_d = scan_cnt_q;
    ir_data_d  = ir_data_q;
    line_d     = line_q;
    vld_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          state_d = S_SETTLE;
          ir_en_d = 1'b1;
          cnt_d   = '0;
        end
      end

      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          state_d = S_FRAME;
          frame_d = '0;
          ss_n_d  = 1'b0;
          tx_d    = addr_word(4'd0);
          cnt_d   = '0;
          evt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Half-period events: even = SCLK fall + MOSI shift, odd = SCLK rise + MISO sample,
      // event 32 closes the frame half a period after the 16th rise.
      S_FRAME: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          evt_d = evt_q + 6'd1;
          if (evt_q == 6'(LAST_EVT)) begin
            ss_n_d  = 1'b1;
            mosi_d  = 1'b0;
            frame_d = frame_q + 4'd1;
            for (int k = 0; k < NUM_CH; k++) begin
              if (frame_q == 4'(k + 1)) acc_d[k] = acc_q[k] + ACC_W'(inv_sample);
            end
            if (frame_q == 4'(FRAMES - 1)) begin
              state_d = S_ACCUM;
              ir_en_d = 1'b0;
            end else begin
              state_d = S_GAP;
            end
          end else if (!evt_q[0]) begin
            sclk_d = 1'b0;
            mosi_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[14:0], MISO};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          state_d = S_FRAME;
          ss_n_d  = 1'b0;
          tx_d    = addr_word(frame_q);
          cnt_d   = '0;
          evt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ACCUM: begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        state_d    = (scan_cnt_q == SW'(NSCAN - 1)) ? S_PUBLISH : S_IDLE;
      end

      S_PUBLISH: begin
        line_d = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
          ir_data_d[k] = 12'(acc_q[k] >> AVG_LOG2);
          if (ir_data_d[k] > line_thresh) line_d = 1'b1;
          acc_d[k] = '0;
        end
        vld_d      = 1'b1;
        scan_cnt_d = '0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      cnt_q      <= '0;
      evt_q      <= '0;
      frame_q    <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sclk_q     <= 1'b1;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ir_en_q    <= 1'b0;
      scan_cnt_q <= '0;
      ir_data_q  <= '0;
      line_q     <= 1'b0;
      vld_q      <= 1'b0;
      // NOTE: the accumulator array is a handful of flops, not RAM, so it is reset to drop partial averages.
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
      frame_q    <= frame_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      ir_en_q    <= ir_en_d;
      scan_cnt_q <= scan_cnt_d;
      ir_data_q  <= ir_data_d;
      line_q     <= line_d;
      vld_q      <= vld_d;
      acc_q      <= acc_d;
    end
  end

  assign MOSI         = mosi_q;
  assign SCLK         = sclk_q;
  assign SS_n         = ss_n_q;
  assign IR_en        = ir_en_q;
  assign ir_data      = ir_data_q;
  assign ir_vld       = vld_q;
  assign line_present = line_q;

endmodule

// File: doc/ir_scan_intf.md
Name: ir_scan_intf

Overview:
- Parametrised next-generation IR line-sensor interface.
- Periodically powers the IR emitters and scans NUM_CH channels of an ADC128S-compatible SPI ADC.
- Inverts each reading, optionally averages over 2^AVG_LOG2 scans, and publishes a packed result bus, a valid pulse and a runtime-thresholded line_present flag.
- Sits between the ADC SPI pins and the line-following steering logic.

Parameters:
- NUM_CH, 8, channels scanned per pass (1..8); channel k maps to ADC input k.
- SCLK_DIV, 32, system clocks per SCLK period (even, >=4).
- SETTLE_CYC, 1024, clocks IR_en is high before the first SPI frame of a scan.
- PERIOD_CYC, 8192, clocks between scan starts (must exceed one full scan).
- AVG_LOG2, 0, log2 of scans averaged per published result (0..3).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, scan enable; when low no new scan starts.
- line_thresh, input, 12, line detect threshold, sampled when results are published.
- MISO, input, 1, ADC serial data in.
- MOSI, output, 1, ADC serial data out (channel address).
- SCLK, output, 1, SPI clock, idles high.
- SS_n, output, 1, ADC select, active low.
- IR_en, output, 1, IR emitter enable.
- ir_data, output, 12*NUM_CH, averaged inverted readings; channel k at [12k+11:12k].
- ir_vld, output, 1, one-cycle pulse when ir_data/line_present update.
- line_present, output, 1, high if any published channel > line_thresh.

Behaviour:
- Reset values: SS_n=1, SCLK=1, MOSI=0, IR_en=0, ir_vld=0, line_present=0, ir_data=0. Accumulators, scan counter and period timer are cleared.
- Period timer: free-running while en=1; a scan starts when it reaches PERIOD_CYC-1, then it wraps to 0. While en=0 the timer holds at 0.
- FSM states: IDLE, SETTLE, FRAME, GAP, ACCUM, PUBLISH.
  - IDLE: on scan start go to SETTLE and set IR_en=1.
  - SETTLE: wait SETTLE_CYC clocks, then go to FRAME.
  - FRAME/GAP: perform NUM_CH+1 SPI frames; at least 2 clocks of GAP with SS_n=1 between frames.
  - ACCUM: entered after the last frame; IR_en=0.
  - PUBLISH: after 2^AVG_LOG2 completed scans.
- SPI frame:
  - SS_n falls, then SCLK falls SCLK_DIV/2 clocks later.
  - 16 SCLK periods per frame.
  - MOSI changes on SCLK falling edge, MSB first; frame j carries the ADC address j (j<NUM_CH, else 0) in bits [13:11], other bits 0.
  - MISO is sampled on SCLK rising edge.
  - SS_n rises SCLK_DIV/2 clocks after the 16th rising edge, with SCLK high.
- ADC pipelining: the result of frame j is the channel addressed in frame j-1, so frame 0's data is discarded. The low 12 bits of frame j (j>=1) give channel j-1.
- Accumulation: acc[k] (12+AVG_LOG2 bits) += ~sample[11:0], with no overflow by construction.
- PUBLISH:
  - ir_data[k] = acc[k] >> AVG_LOG2, truncating.
  - line_present = OR over k of (ir_data[k] > line_thresh), unsigned strict compare.
  - ir_vld pulses for exactly 1 clock, concurrent with the updated outputs.
  - Accumulators and scan count are then cleared.
  - ir_data and line_present hold between publishes.
- en falling mid-scan: the current scan completes and is accumulated. A partial average is never published; the accumulated scans are kept and continue when en returns.
- Asynchronous reset mid-frame: SS_n and SCLK go high and IR_en goes low immediately. The partial average is discarded.
- NUM_CH=1: 2 frames per scan. Unused upper address values are never driven.

Test Plan:
- Bench setup for all scenarios: the ADC128S model returns 0xC00-0x80*s-0xF*k for scan s, channel k.
- NUM_CH=8, AVG_LOG2=0, en=1: first ir_vld -> ch0..ch7 = 3FF,40E,41D,42C,43B,44A,459,468; second -> 47F,48E,...,4E8. Timeout 30000 clocks.
- AVG_LOG2=1, NUM_CH=8: ir_vld appears only after 2 scans; ch0=0x43F, ch7=0x4A8. Exactly one ir_vld per 2 scans.
- line_thresh: with 0x460 and scan 0 -> line_present=1; with 0x470 -> 0. Equal value 0x468 -> 0 (strict compare).
- SPI protocol checker: each frame has 16 SCLK rises with SS_n low; address bits match j; IR_en high ≥ SETTLE_CYC before first SS_n fall and low after the last frame. SCLK period = SCLK_DIV.
- en deasserted mid-scan: the scan finishes, then no SS_n activity for 3*PERIOD_CYC. Re-enable -> the next ir_vld carries the correct next-scan values.
- rst_n asserted mid-frame: SS_n=1, SCLK=1, IR_en=0, ir_data=0 in the same cycle. After release the first ir_vld has a complete, correct scan.
